nx_ram_2rw_ctl: RTL and testbench

NX_RAM_2RW_CTL -- requirements
Module: nx_ram_2rw_ctl

---
 rtl/nx_ram_2rw_ctl_pkg.sv | 18 +
 rtl/nx_ram_2rw_ctl_rsp_pipe.sv | 34 +++
 rtl/nx_ram_2rw_ctl.sv | 169 ++++++++++++++++
 tb/tb_nx_ram_2rw_ctl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_ram_2rw_ctl_pkg.sv
// Shared types for the two-requester RAM controller.
// FSM state, port-select codes and the response tracking entry.
package nx_ram_2rw_ctl_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic valid;
    logic sel;
  } trk_t;

endpackage

// File: rtl/nx_ram_2rw_ctl_rsp_pipe.sv
// Per-requester read tracker: an L-deep shift register of {valid, port}.
// The tail entry marks the cycle the RAM presents that read's data.
module nx_ram_2rw_ctl_rsp_pipe
  import nx_ram_2rw_ctl_pkg::*;
#(
  parameter int L = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_sel,
  output logic out_valid,
  output logic out_sel
);

  trk_t stg [L];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < L; k++) begin
        stg[k] <= '0;
      end
    end else begin
      stg[0] <= '{valid: in_valid, sel: in_sel};
      for (int k = 1; k < L; k++) begin
        stg[k] <= stg[k-1];
      end
    end
  end

  assign out_valid = stg[L-1].valid;
  assign out_sel   = stg[L-1].sel;

endmodule

// File: rtl/nx_ram_2rw_ctl.sv
// Two-requester front end for a 1R + 1RW dual-port RAM.
// Port A serves reads only; port B takes writes, zero-fill and spill reads.
module nx_ram_2rw_ctl
  import nx_ram_2rw_ctl_pkg::*;
#(
  parameter  int WIDTH      = 64,
  parameter  int DEPTH      = 256,
  parameter  int RD_LATENCY = 1,
  parameter  int IN_FLOP    = 0,
  parameter  int INIT_ZERO  = 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_wr,
  input  logic [1:0][AW-1:0]    req_addr,
  input  logic [1:0][WIDTH-1:0] req_data,
  input  logic [1:0][WIDTH-1:0] req_bwe,
  output logic [1:0]            rsp_valid,
  output logic [1:0][WIDTH-1:0] rsp_data,
  output logic                  ram_csa,
  output logic                  ram_wea,
  output logic [AW-1:0]         ram_adda,
  output logic [WIDTH-1:0]      ram_dina,
  output logic [WIDTH-1:0]      ram_bwea,
  input  logic [WIDTH-1:0]      ram_douta,
  output logic                  ram_csb,
  output logic                  ram_web,
  output logic [AW-1:0]         ram_addb,
  output logic [WIDTH-1:0]      ram_dinb,
  output logic [WIDTH-1:0]      ram_bweb,
  input  logic [WIDTH-1:0]      ram_doutb,
  output logic                  init_done
);

  localparam int L = RD_LATENCY + 1 + IN_FLOP;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic          rr;
  logic          run;
  logic          fill;
  logic [1:0]    v;
  logic [1:0]    wr;
  logic [1:0]    acc_rd;
  logic [1:0]    acc_wr;
  logic [1:0]    rd_port;
  logic [1:0]    pipe_sel;

  assign run  = (state == RUN) && !rst;
  assign fill = (state == INIT) && !rst;
  assign v    = req_valid & {2{run}};
  assign wr   = v & req_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (INIT_ZERO != 0) ? INIT : RUN;
      cnt   <= '0;
      rr    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == INIT) begin
        cnt <= cnt + 1'b1;
      end
      // The loser of a write/write clash wins the next one.
      if (&wr) begin
        rr <= ~rr;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && cnt == AW'(DEPTH - 1)) begin
      state_nxt = RUN;
    end
  end

  always_comb begin
    if (&wr) begin
      req_ready = rr ? 2'b10 : 2'b01;
    end else begin
      req_ready = v;
    end
  end

  assign acc_rd = req_ready & ~req_wr;
  assign acc_wr = req_ready & req_wr;

  assign ram_wea  = 1'b0;
  assign ram_dina = '0;
  assign ram_bwea = '0;

  always_comb begin
    ram_csa  = 1'b0;
    ram_adda = '0;
    ram_csb  = 1'b0;
    ram_web  = 1'b0;
    ram_addb = '0;
    ram_dinb = '0;
    ram_bweb = '0;
    rd_port  = {PORT_A, PORT_A};
    if (fill) begin
      ram_csb  = 1'b1;
      ram_web  = 1'b1;
      ram_addb = cnt;
      ram_bweb = '1;
    end else begin
      unique case (acc_wr)
        2'b01: begin
          ram_csb  = 1'b1;
          ram_web  = 1'b1;
          ram_addb = req_addr[0];
          ram_dinb = req_data[0];
          ram_bweb = req_bwe[0];
        end
        2'b10: begin
          ram_csb  = 1'b1;
          ram_web  = 1'b1;
          ram_addb = req_addr[1];
          ram_dinb = req_data[1];
          ram_bweb = req_bwe[1];
        end
        default: ;
      endcase
      // Only a read/read pair can leave port B free for a read.
      unique case (acc_rd)
        2'b11: begin
          ram_csa    = 1'b1;
          ram_adda   = req_addr[0];
          ram_csb    = 1'b1;
          ram_addb   = req_addr[1];
          rd_port[1] = PORT_B;
        end
        2'b01: begin
          ram_csa  = 1'b1;
          ram_adda = req_addr[0];
        end
        2'b10: begin
          ram_csa  = 1'b1;
          ram_adda = req_addr[1];
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_rsp
    nx_ram_2rw_ctl_rsp_pipe #(
      .L(L)
    ) u_pipe (
      .clk      (clk),
      .rst      (rst),
      .in_valid (acc_rd[i]),
      .in_sel   (rd_port[i]),
      .out_valid(rsp_valid[i]),
      .out_sel  (pipe_sel[i])
    );

    assign rsp_data[i] =
      (pipe_sel[i] == PORT_B) ? ram_doutb : ram_douta;
  end

  assign init_done = rst ? (INIT_ZERO == 0) : (state == RUN);

endmodule

// File: tb/tb_nx_ram_2rw_ctl.sv
// Directed bench for nx_ram_2rw_ctl with a read-first dual-port RAM model.
// RAM contents start as 0xDEAD so the zero-fill is observable.
module tb_nx_ram_2rw_ctl;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int L  = 2;

  logic               clk = 0;
  logic               rst;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_wr;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][W-1:0]  req_data;
  logic [1:0][W-1:0]  req_bwe;
  logic [1:0]         rsp_valid;
  logic [1:0][W-1:0]  rsp_data;
  logic               ram_csa, ram_wea, ram_csb, ram_web;
  logic [AW-1:0]      ram_adda, ram_addb;
  logic [W-1:0]       ram_dina, ram_bwea, ram_douta;
  logic [W-1:0]       ram_dinb, ram_bweb, ram_doutb;
  logic               init_done;

  int n_chk;
  int n_fail;

  always #5 clk = ~clk;

  nx_ram_2rw_ctl #(
    .WIDTH(W), .DEPTH(D), .RD_LATENCY(1),
    .IN_FLOP(0), .INIT_ZERO(1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr),
    .req_data(req_data), .req_bwe(req_bwe),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_csa(ram_csa), .ram_wea(ram_wea),
    .ram_adda(ram_adda), .ram_dina(ram_dina),
    .ram_bwea(ram_bwea), .ram_douta(ram_douta),
    .ram_csb(ram_csb), .ram_web(ram_web),
    .ram_addb(ram_addb), .ram_dinb(ram_dinb),
    .ram_bweb(ram_bweb), .ram_doutb(ram_doutb),
    .init_done(init_done)
  );

  logic [W-1:0] mem [D];
  logic [W-1:0] pa  [L];
  logic [W-1:0] pb  [L];

  initial begin
    for (int i = 0; i < D; i++) mem[i] = 16'hDEAD;
    for (int i = 0; i < L; i++) begin
      pa[i] = '0;
      pb[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (ram_csa && !ram_wea) pa[0] <= mem[ram_adda];
    if (ram_csb && !ram_web) pb[0] <= mem[ram_addb];
    for (int k = 1; k < L; k++) begin
      pa[k] <= pa[k-1];
      pb[k] <= pb[k-1];
    end
    if (ram_csb && ram_web)
      mem[ram_addb] <= (mem[ram_addb] & ~ram_bweb)
                     | (ram_dinb & ram_bweb);
  end

  assign ram_douta = pa[L-1];
  assign ram_doutb = pb[L-1];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_data  = '0;
    req_bwe   = '0;
  endtask

  task automatic set_req(input int i, input logic w,
                         input logic [AW-1:0] a,
                         input logic [W-1:0] d);
    req_valid[i] = 1'b1;
    req_wr[i]    = w;
    req_addr[i]  = a;
    req_data[i]  = d;
    req_bwe[i]   = '1;
  endtask

  // Called one cycle after acceptance; expects data L cycles after it.
  task automatic wait_rsp(input int i, input logic [W-1:0] exp,
                          input string tag);
    int n;
    n = 1;
    while (!rsp_valid[i] && n < 10) begin
      cyc();
      n++;
    end
    check({tag, "_lat"}, n, L);
    check({tag, "_data"}, rsp_data[i], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int k;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle();
    repeat (3) cyc();

    req_valid = 2'b11;
    #1;
    check("rst_ready", req_ready, 2'b00);
    check("rst_rsp", rsp_valid, 2'b00);
    check("rst_cs", {ram_csa, ram_csb, ram_wea, ram_web}, 4'b0);
    check("rst_done", init_done, 1'b0);

    rst = 1'b0;
    #1;
    check("fill_ctl", {ram_csb, ram_web, ram_dinb, ram_bweb},
          {1'b1, 1'b1, 16'h0000, 16'hFFFF});
    k = 0;
    while (!init_done && k < 40) begin
      check("fill_addr", ram_addb, k);
      check("fill_ready", req_ready, 2'b00);
      cyc();
      k++;
    end
    idle();
    check("init_cycles", k, 16);

    set_req(0, 0, 5, 0);
    #1;
    check("rd5_ready", req_ready, 2'b01);
    check("rd5_porta", {ram_csa, ram_adda, ram_csb}, {1'b1, 4'd5, 1'b0});
    cyc(); idle();
    wait_rsp(0, 16'h0000, "rd5");

    set_req(0, 1, 3, 16'h00A5);
    #1;
    check("wr3_ready", req_ready, 2'b01);
    check("wr3_portb", {ram_csa, ram_csb, ram_web, ram_addb, ram_dinb},
          {1'b0, 1'b1, 1'b1, 4'd3, 16'h00A5});
    check("wea_tied", {ram_wea, ram_dina, ram_bwea}, '0);
    cyc(); idle();
    set_req(0, 0, 3, 0);
    cyc(); idle();
    wait_rsp(0, 16'h00A5, "rd3");

    set_req(0, 1, 6, 16'hFFFF);
    req_bwe[0] = 16'h00F0;
    #1;
    check("bwe_pass", ram_bweb, 16'h00F0);
    cyc(); idle();
    set_req(0, 0, 6, 0);
    cyc(); idle();
    wait_rsp(0, 16'h00F0, "rd6_bwe");

    set_req(0, 1, 1, 16'h0011);
    set_req(1, 1, 2, 16'h0022);
    #1;
    check("ww1_ready", req_ready, 2'b01);
    check("ww1_b", {ram_addb, ram_dinb}, {4'd1, 16'h0011});
    cyc();
    #1;
    check("ww2_ready", req_ready, 2'b10);
    check("ww2_b", {ram_addb, ram_dinb}, {4'd2, 16'h0022});
    cyc();
    #1;
    check("rr_back", req_ready, 2'b01);
    idle();
    set_req(0, 0, 1, 0);
    set_req(1, 0, 2, 0);
    #1;
    check("rr2_ready", req_ready, 2'b11);
    check("rr2_ports", {ram_csa, ram_adda, ram_csb, ram_web, ram_addb},
          {1'b1, 4'd1, 1'b1, 1'b0, 4'd2});
    cyc(); idle();
    wait_rsp(0, 16'h0011, "rr2_rd0");
    check("rr2_rd1", {rsp_valid[1], rsp_data[1]}, {1'b1, 16'h0022});

    set_req(0, 1, 4, 16'h0077);
    set_req(1, 0, 4, 0);
    #1;
    check("wr_rd_ready", req_ready, 2'b11);
    check("wr_rd_ports", {ram_csa, ram_adda, ram_csb, ram_web, ram_addb},
          {1'b1, 4'd4, 1'b1, 1'b1, 4'd4});
    cyc(); idle();
    wait_rsp(1, 16'h0000, "rw_old");
    set_req(1, 0, 4, 0);
    #1;
    check("r1_porta", {ram_csa, ram_csb}, 2'b10);
    cyc(); idle();
    wait_rsp(1, 16'h0077, "rw_new");

    set_req(1, 1, 7, 16'h0033);
    set_req(0, 0, 3, 0);
    #1;
    check("w1r0_ready", req_ready, 2'b11);
    check("w1r0_ports", {ram_adda, ram_addb, ram_dinb},
          {4'd3, 4'd7, 16'h0033});
    cyc(); idle();
    wait_rsp(0, 16'h00A5, "w1r0_rd");
    set_req(0, 0, 7, 0);
    cyc(); idle();
    wait_rsp(0, 16'h0033, "rd7");

    for (int i = 0; i < 8; i++) begin
      set_req(0, 1, 4'(i), 16'(16'h0100 + i));
      cyc();
    end
    idle();
    for (int j = 0; j < 11; j++) begin
      idle();
      if (j < 8) begin
        set_req(0, 0, 4'(j), 0);
        set_req(1, 0, 4'(7 - j), 0);
      end
      #1;
      if (j < 8) check("b2b_ready", req_ready, 2'b11);
      if (j >= 2 && j < 10) begin
        check("b2b_valid", rsp_valid, 2'b11);
        check("b2b_d0", rsp_data[0], 16'(16'h0100 + j - 2));
        check("b2b_d1", rsp_data[1], 16'(16'h0107 - (j - 2)));
      end else begin
        check("b2b_quiet", rsp_valid, 2'b00);
      end
      cyc();
    end
    idle();

    set_req(0, 1, 9, 16'h0001);
    set_req(1, 1, 10, 16'h0002);
    #1;
    check("pre_rst_ww", req_ready, 2'b01);
    cyc(); idle();
    set_req(0, 0, 1, 0);
    set_req(1, 0, 2, 0);
    cyc(); idle();
    rst = 1'b1;
    #1;
    check("inflight_rst0", rsp_valid, 2'b00);
    cyc();
    check("inflight_rst1", rsp_valid, 2'b00);
    cyc();
    rst = 1'b0;
    #1;
    check("reinit_addr0", {ram_csb, ram_web, ram_addb},
          {1'b1, 1'b1, 4'd0});
    for (int i = 0; i < 4; i++) begin
      check("inflight_drop", rsp_valid, 2'b00);
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("restart_addr0", ram_addb, 4'd0);
    k = 0;
    while (!init_done && k < 40) begin
      cyc();
      k++;
    end
    check("reinit_cycles", k, 16);

    set_req(0, 1, 11, 16'h0005);
    set_req(1, 1, 12, 16'h0006);
    #1;
    check("rr_reset", req_ready, 2'b01);
    cyc(); idle();
    set_req(1, 0, 9, 0);
    cyc(); idle();
    wait_rsp(1, 16'h0000, "refill_zero");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
